// File: rtl/lc3_mem_responder_if.sv
// LC-3 control unit <-> memory responder bus: multi-cycle OE/WE strobes, address, data and status.
// The master is the control unit; the slave is the responder. Switches and Hex_out carry the MMIO word.
interface lc3_mem_responder_if;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_to_mem;
  logic [15:0] Data_from_mem;
  logic        Mem_ready;
  logic        Busy;
  logic        Err;
  logic [15:0] Switches;
  logic [15:0] Hex_out;

  modport master (
    output Mem_OE, Mem_WE, ADDR, Data_to_mem, Switches,
    input  Data_from_mem, Mem_ready, Busy, Err, Hex_out
  );

  modport slave (
    input  Mem_OE, Mem_WE, ADDR, Data_to_mem, Switches,
    output Data_from_mem, Mem_ready, Busy, Err, Hex_out
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// On-chip RAM responder: read data valid in strobe cycle READ_LAT, write commits in cycle WRITE_LAT (both >= 2).
// Define LC3_MEM_MMIO_EN to map full address xFFFF to Switches (read) and Hex_out (write).
module lc3_mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  lc3_mem_responder_if.slave bus
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int DEPTH   = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DONE,
    WRITE_WAIT,
    WRITE_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              mmio_q;
  logic [15:0]       data_q;
  logic              rdy_q;
  logic              err_q;

  logic latch_addr, ld_data, set_rdy, clr_rdy, commit, set_err;
  logic rd_only, wr_only, both_hi, in_read;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_addr;
  logic              addr_is_mmio;
  logic              rd_mmio;
  logic [15:0]       rd_word;

  assign rd_only = bus.Mem_OE & ~bus.Mem_WE;
  assign wr_only = bus.Mem_WE & ~bus.Mem_OE;
  assign both_hi = bus.Mem_OE & bus.Mem_WE;

`ifdef LC3_MEM_MMIO_EN
  assign addr_is_mmio = (bus.ADDR == 16'hFFFF);
`else
  logic unused_bits;
  assign addr_is_mmio = 1'b0;
  assign unused_bits  = ^{bus.ADDR[15:ADDR_W], bus.Switches};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds how many strobe cycles have already completed, so during cycle k it reads k-1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_addr = 1'b0;
    ld_data    = 1'b0;
    set_rdy    = 1'b0;
    clr_rdy    = 1'b0;
    commit     = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (both_hi) begin
          set_err = 1'b1;
        end else if (rd_only) begin
          state_d    = READ_WAIT;
          cnt_d      = CNT_W'(1);
          latch_addr = 1'b1;
          if (READ_LAT == 2) begin
            ld_data = 1'b1;
            set_rdy = 1'b1;
          end
        end else if (wr_only) begin
          state_d    = WRITE_WAIT;
          cnt_d      = CNT_W'(1);
          latch_addr = 1'b1;
          if (WRITE_LAT == 2) begin
            set_rdy = 1'b1;
          end
        end
      end
      READ_WAIT: begin
        if (!rd_only) begin
          set_err = both_hi;
          clr_rdy = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(READ_LAT - 2)) begin
            ld_data = 1'b1;
            set_rdy = 1'b1;
          end
          if (cnt_q == CNT_W'(READ_LAT - 1)) begin
            state_d = READ_DONE;
          end
        end
      end
      READ_DONE: begin
        if (!rd_only) begin
          set_err = both_hi;
          clr_rdy = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WRITE_WAIT: begin
        if (!wr_only) begin
          set_err = both_hi;
          clr_rdy = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WRITE_LAT - 2)) begin
            set_rdy = 1'b1;
          end
          if (cnt_q == CNT_W'(WRITE_LAT - 1)) begin
            commit  = 1'b1;
            state_d = WRITE_DONE;
          end
        end
      end
      WRITE_DONE: begin
        if (!wr_only) begin
          set_err = both_hi;
          clr_rdy = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        clr_rdy = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // In IDLE the read port looks straight at ADDR so a two-cycle read can load at the end of cycle 1.
  assign rd_addr = (state_q == IDLE) ? bus.ADDR[ADDR_W-1:0] : addr_q;
  assign rd_mmio = (state_q == IDLE) ? addr_is_mmio : mmio_q;

  always_comb begin
    rd_word = mem[rd_addr];
`ifdef LC3_MEM_MMIO_EN
    if (rd_mmio) begin
      rd_word = bus.Switches;
    end
`else
    if (rd_mmio) begin
      rd_word = '0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q <= '0;
      mmio_q <= 1'b0;
      data_q <= '0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (latch_addr) begin
        addr_q <= bus.ADDR[ADDR_W-1:0];
        mmio_q <= addr_is_mmio;
      end
      if (ld_data) begin
        data_q <= rd_word;
      end
      if (set_rdy) begin
        rdy_q <= 1'b1;
      end else if (clr_rdy) begin
        rdy_q <= 1'b0;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Array contents survive reset; a reset in the commit cycle discards the write.
  always_ff @(posedge Clk) begin
    if (commit && !mmio_q && !Reset) begin
      mem[addr_q] <= bus.Data_to_mem;
    end
  end

`ifdef LC3_MEM_MMIO_EN
  logic [15:0] hex_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hex_q <= '0;
    end else if (commit && mmio_q) begin
      hex_q <= bus.Data_to_mem;
    end
  end

  assign bus.Hex_out = hex_q;
`else
  assign bus.Hex_out = '0;
`endif

  assign in_read           = (state_q == READ_WAIT) || (state_q == READ_DONE);
  assign bus.Mem_ready     = rdy_q & (in_read ? rd_only : wr_only);
  assign bus.Busy          = (state_q != IDLE);
  assign bus.Err           = err_q;
  assign bus.Data_from_mem = data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: transaction table, hand-written corner sequences, then random strobes
// checked cycle by cycle against a strobe-count reference model.
module tb_lc3_mem_responder;
  localparam int RL = 4;
  localparam int WL = 4;
  localparam int AW = 10;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  lc3_mem_responder_if bus();

  lc3_mem_responder #(.ADDR_W(AW), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        oe;
    logic        we;
    int          n;
    logic [15:0] addr;
    logic [15:0] din;
    int          first_rdy;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vt [9];

  // reference model state
  int          m_op;
  int          m_k;
  logic [15:0] m_addr;
  logic        m_mmio;
  logic [15:0] m_data;
  logic [15:0] m_hex;
  logic        m_err;
  logic [15:0] mm [1024];
  logic [15:0] aset [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic oe, input logic we, input logic [15:0] addr,
                       input logic [15:0] din, input logic rst);
    bus.Mem_OE      = oe;
    bus.Mem_WE      = we;
    bus.ADDR        = addr;
    bus.Data_to_mem = din;
    Reset           = rst;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic oe, input logic we, input int n,
                        input logic [15:0] addr, input logic [15:0] din,
                        input int first_rdy, input logic [15:0] exp_data);
    for (int k = 1; k <= n; k++) begin
      drive(oe, we, addr, din, 1'b0);
      @(negedge Clk);
      chk({name, " ready"}, bus.Mem_ready, k >= first_rdy);
      chk({name, " busy"}, bus.Busy, k > 1);
      next_cycle();
    end
    drive(1'b0, 1'b0, addr, din, 1'b0);
    @(negedge Clk);
    chk({name, " ready after drop"}, bus.Mem_ready, 1'b0);
    chk({name, " busy after drop"}, bus.Busy, 1'b1);
    next_cycle();
    @(negedge Clk);
    chk({name, " idle busy"}, bus.Busy, 1'b0);
    chk({name, " data"}, bus.Data_from_mem, exp_data);
    chk({name, " err"}, bus.Err, 1'b0);
    next_cycle();
  endtask

  function automatic logic is_mmio(input logic [15:0] a);
`ifdef LC3_MEM_MMIO_EN
    return a == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic [1:0]  pat;
    logic        oe, we, rst, rd, wr, cont, e_rdy, e_busy;
    logic [15:0] addr, din, sw;
    int          lat;

    vt[0] = '{1'b0, 1'b1, 4, 16'h0003, 16'h1234, WL, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 4, 16'h0003, 16'h0000, RL, 16'h1234};
    vt[2] = '{1'b0, 1'b1, 2, 16'h0003, 16'hBEEF, 99, 16'h1234};
    vt[3] = '{1'b1, 1'b0, 4, 16'h0003, 16'h0000, RL, 16'h1234};
    vt[4] = '{1'b0, 1'b1, 6, 16'h0007, 16'hAAAA, WL, 16'h1234};
    vt[5] = '{1'b1, 1'b0, 4, 16'h0007, 16'h0000, RL, 16'hAAAA};
    vt[6] = '{1'b1, 1'b0, 7, 16'h0003, 16'h0000, RL, 16'h1234};
    vt[7] = '{1'b0, 1'b1, 4, 16'h0405, 16'h5A5A, WL, 16'h1234};
    vt[8] = '{1'b1, 1'b0, 4, 16'h0005, 16'h0000, RL, 16'h5A5A};

    bus.Switches = 16'h0000;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    next_cycle();
    next_cycle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge Clk);
    chk("reset data", bus.Data_from_mem, 16'h0000);
    chk("reset ready/busy/err", {bus.Mem_ready, bus.Busy, bus.Err}, 3'b000);
    chk("reset hex", bus.Hex_out, 16'h0000);
    next_cycle();

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vt[i].oe, vt[i].we, vt[i].n, vt[i].addr,
             vt[i].din, vt[i].first_rdy, vt[i].exp_data);

    // address latched in cycle 1; later ADDR points at a word holding xAAAA
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, (k == 1) ? 16'h0003 : 16'h0007, 16'h0000, 1'b0);
      @(negedge Clk);
      chk("latch ready", bus.Mem_ready, k == 4);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0007, 16'h0000, 1'b0);
    next_cycle();
    @(negedge Clk);
    chk("latch data", bus.Data_from_mem, 16'h1234);
    next_cycle();

    // data changing after commit while WE stays high must not be written
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b1, 16'h0009, (k <= 4) ? 16'h1111 : 16'h2222, 1'b0);
      @(negedge Clk);
      chk("hold write ready", bus.Mem_ready, k >= 4);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0009, 16'h0000, 1'b0);
    next_cycle();
    next_cycle();
    run_op("hold readback", 1'b1, 1'b0, 4, 16'h0009, 16'h0000, RL, 16'h1111);

    run_op("top word write", 1'b0, 1'b1, 4, 16'h03FF, 16'h1357, WL, 16'h1111);
    bus.Switches = 16'h00FF;
`ifdef LC3_MEM_MMIO_EN
    run_op("mmio read", 1'b1, 1'b0, 4, 16'hFFFF, 16'h0000, RL, 16'h00FF);
    run_op("mmio write", 1'b0, 1'b1, 4, 16'hFFFF, 16'hC0DE, WL, 16'h00FF);
    chk("mmio hex", bus.Hex_out, 16'hC0DE);
    run_op("top word kept", 1'b1, 1'b0, 4, 16'h03FF, 16'h0000, RL, 16'h1357);
`else
    run_op("alias read", 1'b1, 1'b0, 4, 16'hFFFF, 16'h0000, RL, 16'h1357);
    run_op("alias write", 1'b0, 1'b1, 4, 16'hFFFF, 16'hC0DE, WL, 16'h1357);
    chk("hex idle", bus.Hex_out, 16'h0000);
    run_op("alias readback", 1'b1, 1'b0, 4, 16'h03FF, 16'h0000, RL, 16'hC0DE);
`endif

    // both strobes in IDLE: sticky error, no operation
    drive(1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0);
    @(negedge Clk);
    chk("both idle err before", bus.Err, 1'b0);
    chk("both idle busy", bus.Busy, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0);
    @(negedge Clk);
    chk("both idle err set", bus.Err, 1'b1);
    next_cycle();
    @(negedge Clk);
    chk("err sticky", {bus.Err, bus.Busy}, 2'b10);
    next_cycle();

    // reset in cycle 3 of a write aborts it
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 16'h0003, 16'h7777, k == 3);
      @(negedge Clk);
      if (k == 3) chk("busy before reset", bus.Busy, 1'b1);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0);
    @(negedge Clk);
    chk("post reset data", bus.Data_from_mem, 16'h0000);
    chk("post reset flags", {bus.Mem_ready, bus.Busy, bus.Err}, 3'b000);
    chk("post reset hex", bus.Hex_out, 16'h0000);
    next_cycle();
    run_op("no commit after reset", 1'b1, 1'b0, 4, 16'h0003, 16'h0000, RL, 16'h1234);

    // both strobes mid-read abort to IDLE with error
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, k == 3, 16'h0005, 16'h0000, 1'b0);
      next_cycle();
    end
    drive(1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0);
    @(negedge Clk);
    chk("mid-op both abort", {bus.Busy, bus.Err}, 2'b01);
    chk("mid-op both data", bus.Data_from_mem, 16'h1234);
    next_cycle();

    // random phase against the reference model
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    next_cycle();
    m_op = 0; m_k = 0; m_addr = '0; m_mmio = 1'b0;
    m_data = '0; m_hex = '0; m_err = 1'b0;
    for (int i = 0; i < 1024; i++) mm[i] = 16'h0000;
    mm[10'h003] = 16'h1234;
    mm[10'h005] = 16'h5A5A;
    mm[10'h007] = 16'hAAAA;
    mm[10'h009] = 16'h1111;
`ifdef LC3_MEM_MMIO_EN
    mm[10'h3FF] = 16'h1357;
`else
    mm[10'h3FF] = 16'hC0DE;
`endif
    aset[0] = 16'h0003; aset[1] = 16'h0005; aset[2] = 16'h0007; aset[3] = 16'h0009;
    aset[4] = 16'h03FF; aset[5] = 16'h0403; aset[6] = 16'h2409; aset[7] = 16'hFFFF;
    pat = 2'b00;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 15))
          0, 1, 2, 3, 4:      pat = 2'b00;
          5, 6, 7, 8, 9:      pat = 2'b01;
          10, 11, 12, 13, 14: pat = 2'b10;
          default:            pat = 2'b11;
        endcase
      end
      oe   = pat[0];
      we   = pat[1];
      addr = aset[$urandom_range(0, 7)];
      din  = 16'($urandom);
      sw   = 16'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
      drive(oe, we, addr, din, rst);
      bus.Switches = sw;

      rd     = oe & ~we;
      wr     = we & ~oe;
      cont   = (m_op == 1 && rd) || (m_op == 2 && wr);
      lat    = (m_op == 1) ? RL : WL;
      e_rdy  = cont && (m_k + 1 >= lat);
      e_busy = (m_op != 0);
      @(negedge Clk);
      chk($sformatf("random cycle %0d {data,hex,ready,busy,err}", c),
          {bus.Data_from_mem, bus.Hex_out, bus.Mem_ready, bus.Busy, bus.Err},
          {m_data, m_hex, e_rdy, e_busy, m_err});

      if (rst) begin
        m_op = 0; m_k = 0; m_data = '0; m_hex = '0; m_err = 1'b0;
      end else if (cont) begin
        m_k++;
        if (m_op == 1 && m_k == RL - 1) m_data = m_mmio ? sw : mm[m_addr[AW-1:0]];
        if (m_op == 2 && m_k == WL) begin
          if (m_mmio) m_hex = din;
          else        mm[m_addr[AW-1:0]] = din;
        end
      end else begin
        if (oe && we) m_err = 1'b1;
        if (m_op != 0) begin
          m_op = 0;
          m_k  = 0;
        end else if (rd || wr) begin
          m_op   = rd ? 1 : 2;
          m_k    = 1;
          m_addr = addr;
          m_mmio = is_mmio(addr);
          if (rd && m_k == RL - 1) m_data = m_mmio ? sw : mm[m_addr[AW-1:0]];
        end
      end
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
